multicycle_dataflow: RTL and testbench

//  Parametrised multi-cycle successor of the single-cycle datapath. It holds the PC, register file, ALU, IR and

---
 rtl/mcd_pkg.sv | 34 +++
 rtl/mcd_alu.sv | 41 ++++
 rtl/multicycle_dataflow.sv | 169 ++++++++++++++++
 tb/tb_multicycle_dataflow.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcd_pkg.sv
// Shared types and constants for the multi-cycle datapath: FSM states,
// ALU operation codes and instruction-field geometry.
package mcd_pkg;

  // Instruction sequencing states
  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  // ALU operation codes; any other code produces zero
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

  // Fixed-width instruction fields; register fields scale with RAW
  localparam int OPC_W   = 6;
  localparam int FUNCT_W = 4;
  localparam int FIXED_W = OPC_W + FUNCT_W;

  // Total instruction width for a given register-number width
  function automatic int ir_width(input int raw);
    return FIXED_W + 3 * raw;
  endfunction

endpackage

// File: rtl/mcd_alu.sv
// Combinational ALU: arithmetic, logic, signed compare and shifts.
// Shift amount uses only the low log2(DW) bits of the second operand.
module mcd_alu
  import mcd_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] in_1,
  input  logic [DW-1:0] in_2,
  output logic [DW-1:0] out,
  output logic          zero
);

  localparam int SHW = $clog2(DW);

  logic [SHW-1:0] shamt;
  logic           lt;

  assign shamt = in_2[SHW-1:0];
  assign lt    = ($signed(in_1) < $signed(in_2));

  // Select the operation result; unknown codes yield zero
  always_comb begin
    out = '0;
    case (op)
      ALU_ADD: out = in_1 + in_2;
      ALU_SUB: out = in_1 - in_2;
      ALU_AND: out = in_1 & in_2;
      ALU_OR:  out = in_1 | in_2;
      ALU_XOR: out = in_1 ^ in_2;
      ALU_SLT: out = {{(DW-1){1'b0}}, lt};
      ALU_SLL: out = in_1 << shamt;
      ALU_SRL: out = in_1 >> shamt;
      default: out = '0;
    endcase
  end

  assign zero = (out == '0);

endmodule

// File: rtl/multicycle_dataflow.sv
// Multi-cycle datapath: PC, register file, IR, operand/result latches and
// the FETCH/DECODE/EXEC/MEM/WB sequencer. Memories sit outside behind
// req/ack handshakes; control selects come from an external decoder.
module multicycle_dataflow
  import mcd_pkg::*;
#(
  parameter int DW  = 16,
  parameter int PCW = 16,
  parameter int RAW = 2,
  localparam int IW = 10 + 3 * RAW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pc_store,
  input  logic           reg_block_w,
  input  logic           dmem_w,
  input  logic [3:0]     alu_funct,
  input  logic           m1_num,
  input  logic           m2_num,
  input  logic           m3_num,
  input  logic           m4_num,
  input  logic           m5_num,
  input  logic           m6_num,
  input  logic           m7_num,
  output logic [5:0]     opcode,
  output logic [3:0]     funct,
  output logic           alu_zero,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [IW-1:0]  imem_rdata,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [PCW-1:0] dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic           dmem_ack,
  input  logic [DW-1:0]  dmem_rdata,
  output logic           retire
);

  localparam int NREG    = 2 ** RAW;
  localparam int T_LO    = IW - OPC_W - RAW;
  localparam int S1_LO   = T_LO - RAW;
  localparam int CONST_W = RAW + FUNCT_W;
  localparam int J_W     = IW - OPC_W;

  state_t         state_q, state_d;
  logic [PCW-1:0] pc_q;
  logic [IW-1:0]  ir_q;
  logic [DW-1:0]  a_q, b_q, aluout_q, mdr_q;
  logic           zero_q;
  logic [DW-1:0]  regs_q [NREG];

  logic [RAW-1:0]     t_f, s1_f, s2_f, rd_a_num, rd_b_num;
  logic [CONST_W-1:0] const_f;
  logic [J_W-1:0]     j_f;
  logic [DW-1:0]      const_dw, alu_in_1, alu_in_2, alu_out, wb_data;
  logic               alu_zero_c;
  logic [PCW-1:0]     const_pc, pc_inc, pc_next;

  // Instruction field extraction
  assign opcode  = ir_q[IW-1 -: OPC_W];
  assign funct   = ir_q[FUNCT_W-1:0];
  assign t_f     = ir_q[T_LO +: RAW];
  assign s1_f    = ir_q[S1_LO +: RAW];
  assign s2_f    = ir_q[FUNCT_W +: RAW];
  assign const_f = ir_q[CONST_W-1:0];
  assign j_f     = ir_q[J_W-1:0];

  assign const_dw = {{(DW-CONST_W){const_f[CONST_W-1]}}, const_f};
  assign const_pc = {{(PCW-CONST_W){const_f[CONST_W-1]}}, const_f};

  // Operand routing
  assign rd_a_num = m3_num ? s1_f : t_f;
  assign rd_b_num = m4_num ? s2_f : s1_f;
  assign alu_in_1 = m5_num ? b_q : a_q;
  assign alu_in_2 = m6_num ? const_dw : b_q;
  assign wb_data  = m7_num ? mdr_q : aluout_q;

  // PC arithmetic wraps naturally at PCW bits
  assign pc_inc  = pc_q + PCW'(1);
  assign pc_next = m2_num ? {{(PCW-J_W){1'b0}}, j_f}
                          : (m1_num ? pc_inc + const_pc : pc_inc);

  assign imem_addr  = pc_q;
  assign dmem_addr  = aluout_q[PCW-1:0];
  assign dmem_wdata = a_q;
  assign alu_zero   = zero_q;

  mcd_alu #(.DW(DW)) u_alu (
    .op   (alu_funct),
    .in_1 (alu_in_1),
    .in_2 (alu_in_2),
    .out  (alu_out),
    .zero (alu_zero_c)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs; reset silences every request at once
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) state_d = DECODE;
      end
      DECODE: state_d = EXEC;
      EXEC:   state_d = (dmem_w | m7_num) ? MEM : WB;
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dmem_w;
        if (dmem_ack) state_d = WB;
      end
      WB: begin
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      retire   = 1'b0;
    end
  end

  // Datapath latches, register file and PC, each updated in its own phase
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= '0;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
      mdr_q    <= '0;
      zero_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        FETCH: if (imem_ack) ir_q <= imem_rdata;
        DECODE: begin
          a_q <= regs_q[rd_a_num];
          b_q <= regs_q[rd_b_num];
        end
        EXEC: begin
          aluout_q <= alu_out;
          zero_q   <= alu_zero_c;
        end
        MEM: if (dmem_ack) mdr_q <= dmem_rdata;
        WB: begin
          if (reg_block_w) regs_q[t_f] <= wb_data;
          if (pc_store)    pc_q <= pc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_dataflow.sv
// Self-checking bench: directed scenarios followed by random instructions,
// each compared against an instruction-level reference model.
module tb_multicycle_dataflow;

  localparam int DW   = 16;
  localparam int PCW  = 16;
  localparam int RAW  = 2;
  localparam int IW   = 10 + 3 * RAW;
  localparam int NREG = 2 ** RAW;
  localparam int CW   = RAW + 4;
  localparam int JW   = IW - 6;

  typedef struct packed {
    logic       pc_store;
    logic       reg_w;
    logic       dmem_w;
    logic [3:0] fn;
    logic       m1, m2, m3, m4, m5, m6, m7;
  } ctrl_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           pc_store, reg_block_w, dmem_w;
  logic [3:0]     alu_funct;
  logic           m1_num, m2_num, m3_num, m4_num, m5_num, m6_num, m7_num;
  logic [5:0]     opcode;
  logic [3:0]     funct;
  logic           alu_zero, imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, retire;
  logic [PCW-1:0] imem_addr, dmem_addr;
  logic [IW-1:0]  imem_rdata;
  logic [DW-1:0]  dmem_wdata, dmem_rdata;

  always #5 clk = ~clk;

  multicycle_dataflow #(.DW(DW), .PCW(PCW), .RAW(RAW)) dut (
    .clk(clk), .rst(rst), .pc_store(pc_store), .reg_block_w(reg_block_w),
    .dmem_w(dmem_w), .alu_funct(alu_funct),
    .m1_num(m1_num), .m2_num(m2_num), .m3_num(m3_num), .m4_num(m4_num),
    .m5_num(m5_num), .m6_num(m6_num), .m7_num(m7_num),
    .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .retire(retire)
  );

  // Reference model state
  logic [DW-1:0]  m_r [NREG];
  logic [PCW-1:0] m_pc;
  logic [IW-1:0]  m_ir;
  logic           m_zero;
  logic [DW-1:0]  m_mem [logic [PCW-1:0]];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Signed value of the short constant field
  function automatic longint cval(input logic [IW-1:0] ir);
    longint v;
    v = longint'(ir[CW-1:0]);
    if (v >= (longint'(1) << (CW - 1))) v -= (longint'(1) << CW);
    return v;
  endfunction

  function automatic logic [DW-1:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      4'd6: return a << (b % DW);
      4'd7: return a >> (b % DW);
      default: return '0;
    endcase
  endfunction

  function automatic logic [IW-1:0] mk(input int op, input int t, input int s1, input int low);
    logic [IW-1:0] r;
    r = '0;
    r[IW-1 -: 6]       = 6'(op);
    r[IW-7 -: RAW]     = RAW'(t);
    r[IW-7-RAW -: RAW] = RAW'(s1);
    r[CW-1:0]          = CW'(low);
    return r;
  endfunction

  function automatic logic [IW-1:0] mkj(input int op, input int j);
    logic [IW-1:0] r;
    r = '0;
    r[IW-1 -: 6] = 6'(op);
    r[JW-1:0]    = JW'(j);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_r[i] = '0;
    m_pc   = '0;
    m_ir   = '0;
    m_zero = 1'b0;
  endtask

  // Run one instruction through the handshakes and check it against the model
  task automatic exec_instr(input logic [IW-1:0] ir, input ctrl_t c, input int iw, input int dw,
                            input bit force_rd, input logic [DW-1:0] frd, input bit abort_mem);
    int             cyc;
    logic [RAW-1:0] t, s1, s2;
    logic [DW-1:0]  a, b, res, rd;
    logic [PCW-1:0] addr;
    bit             mem;
    t    = ir[IW-7 -: RAW];
    s1   = ir[IW-7-RAW -: RAW];
    s2   = ir[CW-1 -: RAW];
    a    = m_r[c.m3 ? s1 : t];
    b    = m_r[c.m4 ? s2 : s1];
    res  = alu_ref(c.fn, c.m5 ? b : a, c.m6 ? DW'(cval(ir)) : b);
    addr = PCW'(res);
    mem  = c.dmem_w | c.m7;
    if (force_rd)                rd = frd;
    else if (m_mem.exists(addr)) rd = m_mem[addr];
    else                         rd = DW'($urandom);
    cyc = 0;
    for (int w = 0; w <= iw; w++) begin
      @(negedge clk); cyc++;
      chk("fetch_req", imem_req, 1);
      chk("fetch_addr", imem_addr, m_pc);
      chk("ir_hold", opcode, m_ir[IW-1 -: 6]);
      imem_ack   = (w == iw);
      imem_rdata = (w == iw) ? ir : IW'($urandom);
    end
    @(negedge clk); cyc++;
    imem_ack   = 1'b0;
    imem_rdata = IW'($urandom);
    dmem_ack   = 1'b0;
    pc_store = c.pc_store; reg_block_w = c.reg_w; dmem_w = c.dmem_w; alu_funct = c.fn;
    m1_num = c.m1; m2_num = c.m2; m3_num = c.m3; m4_num = c.m4;
    m5_num = c.m5; m6_num = c.m6; m7_num = c.m7;
    chk("decode_opcode", opcode, ir[IW-1 -: 6]);
    chk("decode_funct", funct, ir[3:0]);
    chk("decode_req", imem_req, 0);
    m_ir = ir;
    @(negedge clk); cyc++;
    chk("exec_retire", retire, 0);
    chk("exec_dreq", dmem_req, 0);
    m_zero = (res == '0);
    if (mem) begin
      for (int w = 0; w <= dw; w++) begin
        @(negedge clk); cyc++;
        if (w == 0) chk("alu_zero", alu_zero, m_zero);
        chk("mem_req", dmem_req, 1);
        chk("mem_we", dmem_we, c.dmem_w);
        chk("mem_addr", dmem_addr, addr);
        chk("mem_wdata", dmem_wdata, a);
        if (abort_mem) begin
          rst      = 1'b1;
          dmem_ack = 1'b0;
          @(negedge clk);
          chk("abort_dreq", dmem_req, 0);
          chk("abort_ireq", imem_req, 0);
          chk("abort_retire", retire, 0);
          model_reset();
          rst        = 1'b0;
          dmem_ack   = 1'b1;
          dmem_rdata = DW'($urandom);
          return;
        end
        dmem_ack   = (w == dw);
        dmem_rdata = (w == dw) ? rd : DW'($urandom);
      end
    end
    @(negedge clk); cyc++;
    dmem_ack = 1'b0;
    if (!mem) chk("alu_zero", alu_zero, m_zero);
    chk("wb_retire", retire, 1);
    chk("latency", cyc, 4 + iw + (mem ? 1 + dw : 0));
    if (c.dmem_w) m_mem[addr] = a;
    if (c.reg_w) m_r[t] = c.m7 ? rd : res;
    if (c.pc_store) begin
      if (c.m2)      m_pc = PCW'(ir[JW-1:0]);
      else if (c.m1) m_pc = PCW'(longint'(m_pc) + 1 + cval(ir));
      else           m_pc = m_pc + PCW'(1);
    end
  endtask

  ctrl_t c;

  initial begin
    rst = 1'b1;
    {pc_store, reg_block_w, dmem_w, alu_funct} = '0;
    {m1_num, m2_num, m3_num, m4_num, m5_num, m6_num, m7_num} = '0;
    imem_ack = 1'b0; imem_rdata = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    model_reset();

    // Reset held for two cycles: no requests, cleared flags
    repeat (2) begin
      @(negedge clk);
      chk("rst_imem_req", imem_req, 0);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_retire", retire, 0);
      chk("rst_zero", alu_zero, 0);
      chk("rst_pc", imem_addr, 0);
    end
    rst = 1'b0;

    // R1=5, R2=7 via immediate adds, then R3=R1+R2 with zero-wait fetch
    c = '0; c.fn = 4'd0; c.m3 = 1'b1; c.m6 = 1'b1; c.reg_w = 1'b1; c.pc_store = 1'b1;
    exec_instr(mk(1, 1, 0, 5), c, 0, 0, 0, '0, 0);
    exec_instr(mk(1, 2, 0, 7), c, 0, 0, 0, '0, 0);
    c = '0; c.fn = 4'd0; c.m3 = 1'b1; c.m4 = 1'b1; c.reg_w = 1'b1; c.pc_store = 1'b1;
    exec_instr(mk(2, 3, 1, (2 << 4)), c, 0, 0, 0, '0, 0);

    // Same add with a three-cycle fetch wait
    exec_instr(mk(2, 3, 1, (2 << 4)), c, 3, 0, 0, '0, 0);

    // Store R3 to R3+4, then a load with two wait cycles returning 0x1234
    c = '0; c.fn = 4'd0; c.m6 = 1'b1; c.dmem_w = 1'b1; c.pc_store = 1'b1;
    exec_instr(mk(3, 3, 0, 4), c, 0, 0, 0, '0, 0);
    c = '0; c.fn = 4'd0; c.m3 = 1'b1; c.m6 = 1'b1; c.m7 = 1'b1; c.reg_w = 1'b1; c.pc_store = 1'b1;
    exec_instr(mk(4, 2, 0, 8), c, 0, 2, 1, DW'(16'h1234), 0);
    c = '0; c.fn = 4'd0; c.m6 = 1'b1; c.dmem_w = 1'b1; c.pc_store = 1'b1;
    exec_instr(mk(3, 2, 0, 1), c, 0, 1, 0, '0, 0);

    // Jump to 0x10, branch -2 to 0x0F, jump to top of jump range
    c = '0; c.pc_store = 1'b1; c.m2 = 1'b1;
    exec_instr(mkj(5, 16'h10), c, 0, 0, 0, '0, 0);
    c = '0; c.fn = 4'd1; c.pc_store = 1'b1; c.m1 = 1'b1;
    exec_instr(mk(6, 0, 0, (1 << CW) - 2), c, 0, 0, 0, '0, 0);
    c = '0; c.pc_store = 1'b1; c.m2 = 1'b1;
    exec_instr(mkj(5, (1 << JW) - 1), c, 0, 0, 0, '0, 0);
    // Wrap: jump to 0, branch -2 lands at the top address, branch +1 wraps to 1
    exec_instr(mkj(5, 0), c, 0, 0, 0, '0, 0);
    c = '0; c.fn = 4'd1; c.pc_store = 1'b1; c.m1 = 1'b1;
    exec_instr(mk(6, 0, 0, (1 << CW) - 2), c, 0, 0, 0, '0, 0);
    exec_instr(mk(6, 0, 0, 1), c, 1, 0, 0, '0, 0);
    @(negedge clk);
    chk("wrap_pc", imem_addr, 1);
    exec_instr(mk(6, 0, 0, 1), c, 0, 0, 0, '0, 0);

    // Reset while a load waits for its ack; the late ack must be ignored
    c = '0; c.fn = 4'd0; c.m6 = 1'b1; c.m7 = 1'b1; c.reg_w = 1'b1; c.pc_store = 1'b1;
    exec_instr(mk(4, 1, 1, 2), c, 0, 3, 0, '0, 1);
    c = '0; c.fn = 4'd0; c.m6 = 1'b1; c.dmem_w = 1'b1; c.pc_store = 1'b1;
    exec_instr(mk(3, 1, 0, 0), c, 0, 0, 0, '0, 0);
    exec_instr(mk(3, 3, 0, 0), c, 1, 0, 0, '0, 0);

    // Random instructions, controls and wait states
    for (int k = 0; k < 200; k++) begin
      c = ctrl_t'($urandom);
      exec_instr(IW'($urandom), c, $urandom_range(0, 2), $urandom_range(0, 2), 0, '0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
